// File: rtl/mips_mem_arbiter.sv
// Two-port round-robin arbiter that lets the instruction-fetch and data
// ports of a MIPS core share one single-outstanding memory interface.
// Each transaction runs IDLE -> BUSY -> RESP, and a wait counter aborts
// a stalled BUSY phase so that neither requester can hang forever.
module mips_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // The last BUSY cycle that may still see m_ready before the abort
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    logic          grantData_q;
    logic          lastGrantData_q;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    waitCnt_q;
    logic          err_q;
    logic [DW-1:0] iRdata_q;
    logic [DW-1:0] dRdata_q;
    logic          grantData_d;

    // Decide who wins in IDLE: a lone requester wins outright, and on a tie the
    // port that was not served last time goes next.
    always_comb begin
        grantData_d = d_req && (!i_req || !lastGrantData_q);
    end

    // Main FSM: latches the winning request, waits for memory or the timeout,
    // then spends one cycle acknowledging before arbitration resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grantData_q     <= 1'b0;
            lastGrantData_q <= 1'b1;
            adr_q           <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            waitCnt_q       <= '0;
            err_q           <= 1'b0;
            iRdata_q        <= '0;
            dRdata_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q         <= BUSY;
                        grantData_q     <= grantData_d;
                        lastGrantData_q <= grantData_d;
                        adr_q           <= grantData_d ? d_adr : i_adr;
                        we_q            <= grantData_d & d_we;
                        wdata_q         <= grantData_d ? d_wdata : '0;
                        waitCnt_q       <= '0;
                        err_q           <= 1'b0;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        if (!we_q) begin
                            if (grantData_q) begin
                                dRdata_q <= m_rdata;
                            end else begin
                                iRdata_q <= m_rdata;
                            end
                        end
                        state_q <= RESP;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory side only sees the latched request while BUSY; everything else is
    // held at zero so the bus is quiet between transactions.
    always_comb begin
        m_req   = (state_q == BUSY);
        m_we    = m_req & we_q;
        m_adr   = m_req ? adr_q : '0;
        m_wdata = m_req ? wdata_q : '0;
    end

    // Completion strobes go only to the grantee during the single RESP cycle.
    always_comb begin
        i_ack   = (state_q == RESP) && !grantData_q;
        d_ack   = (state_q == RESP) && grantData_q;
        i_err   = i_ack & err_q;
        d_err   = d_ack & err_q;
        i_rdata = iRdata_q;
        d_rdata = dRdata_q;
    end

endmodule
